// File: rtl/l15_req_retime_buf.sv
// Elastic in-order retiming buffer on the core -> L1.5 request path; breaks the
// header_ack -> req_ack combinational path. Optional stats: L15_REQ_RETIME_STATS_EN.
module l15_req_retime_buf #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned Depth     = 2,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_val_i,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 req_ack_o,
    output logic                 l15_val_o,
    output logic [DataWidth-1:0] l15_data_o,
    input  logic                 l15_header_ack_i,
    output logic [CntWidth-1:0]  occupancy_o,
    output logic [31:0]          stall_cnt_o,
    output logic [CntWidth-1:0]  max_occ_o
);

    localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [CntWidth-1:0]  count;
    logic [CntWidth-1:0]  count_nxt;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign full  = (count == DepthCnt);
    assign empty = (count == '0);

    // Full blocks acceptance even when a pop is in flight, so ack never sees header_ack.
    assign req_ack_o  = req_val_i & ~full;
    assign push       = req_ack_o;
    assign l15_val_o  = ~empty;
    assign pop        = l15_val_o & l15_header_ack_i;
    assign l15_data_o = mem[rd_ptr];
    assign occupancy_o = count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CntWidth'(1);
            2'b01:   count_nxt = count - CntWidth'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
            end
        end
    end

    // Payload storage carries no reset; contents are only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= req_data_i;
        end
    end

`ifdef L15_REQ_RETIME_STATS_EN
    logic [31:0]         stall_cnt_q;
    logic [CntWidth-1:0] max_occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            max_occ_q   <= '0;
        end else begin
            if (req_val_i && !req_ack_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (count_nxt > max_occ_q) begin
                max_occ_q <= count_nxt;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign max_occ_o   = max_occ_q;
`else
    assign stall_cnt_o = '0;
    assign max_occ_o   = '0;
`endif

endmodule

// File: tb/tb_l15_req_retime_buf.sv
// Directed bench for l15_req_retime_buf (Depth=2, DataWidth=8) with an in-order scoreboard.
module tb_l15_req_retime_buf;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_val_i;
    logic [DW-1:0] req_data_i;
    logic          req_ack_o;
    logic          l15_val_o;
    logic [DW-1:0] l15_data_o;
    logic          l15_header_ack_i;
    logic [CW-1:0] occupancy_o;
    logic [31:0]   stall_cnt_o;
    logic [CW-1:0] max_occ_o;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

`ifdef L15_REQ_RETIME_STATS_EN
    localparam logic [31:0] ExpStall = 32'd5;
    localparam logic [31:0] ExpMax   = 32'd2;
`else
    localparam logic [31:0] ExpStall = 32'd0;
    localparam logic [31:0] ExpMax   = 32'd0;
`endif

    l15_req_retime_buf #(.DataWidth(DW), .Depth(2), .CntWidth(CW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_val_i        (req_val_i),
        .req_data_i       (req_data_i),
        .req_ack_o        (req_ack_o),
        .l15_val_o        (l15_val_o),
        .l15_data_o       (l15_data_o),
        .l15_header_ack_i (l15_header_ack_i),
        .occupancy_o      (occupancy_o),
        .stall_cnt_o      (stall_cnt_o),
        .max_occ_o        (max_occ_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard at mid-cycle: the queue length is the model occupancy.
    task automatic mid();
        logic [DW-1:0] exp_d;
        @(negedge clk_i);
        check("sb_val", 32'(l15_val_o), 32'(exp_q.size() != 0));
        check("sb_occ", 32'(occupancy_o), 32'(exp_q.size()));
        if (l15_val_o && l15_header_ack_i && exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            check("sb_order", 32'(l15_data_o), 32'(exp_d));
        end
        if (req_val_i && req_ack_o) exp_q.push_back(req_data_i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_val_i = 1'b0;
        req_data_i = '0;
        l15_header_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_val", 32'(l15_val_o), 32'd0);
        check("rst_ack", 32'(req_ack_o), 32'd0);
        check("rst_occ", 32'(occupancy_o), 32'd0);
        check("rst_stall", stall_cnt_o, 32'd0);
        check("rst_max", 32'(max_occ_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        mid();
        check("idle_ack", 32'(req_ack_o), 32'd0);
        tick();

        // Single push with header_ack held high: one-cycle latency, no bypass.
        req_val_i = 1'b1; req_data_i = 8'hA5; l15_header_ack_i = 1'b1;
        mid();
        check("a5_ack", 32'(req_ack_o), 32'd1);
        check("a5_nobypass", 32'(l15_val_o), 32'd0);
        tick();
        req_val_i = 1'b0;
        mid();
        check("a5_val", 32'(l15_val_o), 32'd1);
        check("a5_data", 32'(l15_data_o), 32'hA5);
        tick();
        l15_header_ack_i = 1'b0;
        mid();
        check("a5_drained", 32'(occupancy_o), 32'd0);
        check("pre_stall", stall_cnt_o, 32'd0);
        tick();

        // Fill, stall on full, then full push+pop collision.
        req_val_i = 1'b1; req_data_i = 8'h11;
        mid();
        check("p11_ack", 32'(req_ack_o), 32'd1);
        tick();
        req_data_i = 8'h22;
        mid();
        check("p22_ack", 32'(req_ack_o), 32'd1);
        check("p22_head", 32'(l15_data_o), 32'h11);
        tick();
        req_data_i = 8'h33;
        mid();
        check("p33_stall", 32'(req_ack_o), 32'd0);
        check("full_occ", 32'(occupancy_o), 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("full_hold_ack", 32'(req_ack_o), 32'd0);
            check("full_hold_data", 32'(l15_data_o), 32'h11);
            tick();
        end
        l15_header_ack_i = 1'b1;
        mid();
        check("full_pop_noack", 32'(req_ack_o), 32'd0);
        check("full_pop_head", 32'(l15_data_o), 32'h11);
        tick();
        l15_header_ack_i = 1'b0;
        mid();
        check("p33_ack_late", 32'(req_ack_o), 32'd1);
        check("after_pop_occ", 32'(occupancy_o), 32'd1);
        tick();
        req_val_i = 1'b0;
        mid();
        check("refill_occ", 32'(occupancy_o), 32'd2);
        check("stats_stall", stall_cnt_o, ExpStall);
        check("stats_max", 32'(max_occ_o), ExpMax);
        tick();
        l15_header_ack_i = 1'b1;
        mid();
        check("out22", 32'(l15_data_o), 32'h22);
        tick();
        mid();
        check("out33", 32'(l15_data_o), 32'h33);
        tick();
        l15_header_ack_i = 1'b0;
        mid();
        check("drain_val", 32'(l15_val_o), 32'd0);
        tick();

        // Asynchronous reset while full drops everything immediately.
        req_val_i = 1'b1; req_data_i = 8'h44;
        mid();
        tick();
        req_data_i = 8'h55;
        mid();
        tick();
        req_val_i = 1'b0;
        mid();
        check("pre_rst_occ", 32'(occupancy_o), 32'd2);
        #2 rst_ni = 1'b0;
        #1;
        check("async_val", 32'(l15_val_o), 32'd0);
        check("async_occ", 32'(occupancy_o), 32'd0);
        check("async_stall", stall_cnt_o, 32'd0);
        check("async_max", 32'(max_occ_o), 32'd0);
        exp_q.delete();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("post_rst_val", 32'(l15_val_o), 32'd0);
            tick();
        end
        req_val_i = 1'b1; req_data_i = 8'h66; l15_header_ack_i = 1'b1;
        mid();
        check("p66_ack", 32'(req_ack_o), 32'd1);
        tick();
        req_val_i = 1'b0;
        mid();
        check("p66_data", 32'(l15_data_o), 32'h66);
        tick();
        l15_header_ack_i = 1'b0;
        mid();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
